// File: rtl/application_fsm.sv
// Moore recogniser for the event pattern a,b,a,a,b on edge-detected inputs a and b.
// Define APPLICATION_OVERLAP_EN for overlapping detection; otherwise detection is non-overlapping.
module application_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic       a,
    input  logic       b,
    output logic       out,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4,
        S5 = 3'd5
    } state_t;

    logic [2:0] r_state;
    logic       r_a_d;
    logic       r_b_d;
    logic       r_out;

    logic       w_ev_a;
    logic       w_ev_b;
    state_t     w_on_a;
    state_t     w_on_b;
    state_t     w_hold;
    state_t     w_next;

    // One event per input pulse, however long it is held.
    assign w_ev_a = a & ~r_a_d;
    assign w_ev_b = b & ~r_b_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= 3'(S0);
            r_a_d   <= 1'b0;
            r_b_d   <= 1'b0;
            r_out   <= 1'b0;
        end else begin
            r_state <= 3'(w_next);
            r_a_d   <= a;
            r_b_d   <= b;
            r_out   <= (w_next == S5);
        end
    end

    // Per-state targets for each event class; unused codes collapse to S0.
    always_comb begin
        w_on_a = S0;
        w_on_b = S0;
        w_hold = S0;
        w_next = S0;
        case (r_state)
            3'(S0): begin w_on_a = S1; w_on_b = S0; w_hold = S0; end
            3'(S1): begin w_on_a = S1; w_on_b = S2; w_hold = S1; end
            3'(S2): begin w_on_a = S3; w_on_b = S0; w_hold = S2; end
            3'(S3): begin w_on_a = S4; w_on_b = S2; w_hold = S3; end
            3'(S4): begin w_on_a = S1; w_on_b = S5; w_hold = S4; end
            3'(S5): begin
`ifdef APPLICATION_OVERLAP_EN
                w_on_a = S3;
`else
                w_on_a = S1;
`endif
                w_on_b = S0;
                w_hold = S5;
            end
            default: begin w_on_a = S0; w_on_b = S0; w_hold = S0; end
        endcase

        if (w_ev_a && w_ev_b)
            w_next = S0;
        else if (w_ev_a)
            w_next = w_on_a;
        else if (w_ev_b)
            w_next = w_on_b;
        else
            w_next = w_hold;
    end

    assign out   = r_out;
    assign state = r_state;

endmodule

// File: tb/tb_application_fsm.sv
// Self-checking bench for application_fsm against a prefix-matching model of the a,b,a,a,b pattern.
module tb_application_fsm;

    logic       clk;
    logic       reset;
    logic       a;
    logic       b;
    logic       out;
    logic [2:0] state;

    int n_checks;
    int n_errors;

    application_fsm dut (
        .clk   (clk),
        .reset (reset),
        .a     (a),
        .b     (b),
        .out   (out),
        .state (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: matched length = longest suffix of the event history that is a pattern prefix.
    int pat [5] = '{1, 2, 1, 1, 2};
    int hist [$];
    int m_state;
    logic pa;
    logic pb;

    function automatic int model_match();
        int n;
        bit ok;
        n = (hist.size() < 5) ? hist.size() : 5;
        for (int k = n; k > 0; k--) begin
            ok = 1'b1;
            for (int j = 0; j < k; j++)
                if (hist[hist.size() - k + j] != pat[j]) ok = 1'b0;
            if (ok) return k;
        end
        return 0;
    endfunction

    task automatic model_clear();
        hist.delete();
        m_state = 0;
        pa = 1'b0;
        pb = 1'b0;
    endtask

    task automatic model_clock(input logic na, input logic nb);
        logic ea;
        logic eb;
        ea = na & ~pa;
        eb = nb & ~pb;
        pa = na;
        pb = nb;
        if (ea && eb) begin
            hist.delete();
            m_state = 0;
        end else if (ea || eb) begin
`ifndef APPLICATION_OVERLAP_EN
            if (m_state == 5) hist.delete();
`endif
            hist.push_back(ea ? 1 : 2);
            while (hist.size() > 5) void'(hist.pop_front());
            m_state = model_match();
        end
    endtask

    // Drive inputs mid-cycle, clock once, advance the model, then settle past the edge.
    task automatic cycle(input logic na, input logic nb);
        @(negedge clk);
        a = na;
        b = nb;
        @(posedge clk);
        model_clock(na, nb);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        a = 1'b0;
        b = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        a = 1'b1;
        b = 1'b0;
        #1;
        n_checks++;
        if (state !== 3'd0 || out !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_async: state=%0d out=%0b expected state=0 out=0", state, out);
        end
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (state !== 3'd0 || out !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_held: state=%0d out=%0b expected state=0 out=0", state, out);
        end
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        cycle(1'b1, 1'b0);
        n_checks++;
        if (state !== 3'd1 || state !== 3'(m_state)) begin
            n_errors++;
            $display("FAIL reset_release_edge: state=%0d expected 1", state);
        end
        cycle(1'b0, 1'b0);
    endtask

    task automatic test_long_pulse();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0);
            n_checks++;
            if (state !== 3'd1 || out !== 1'b0) begin
                n_errors++;
                $display("FAIL long_pulse[%0d]: state=%0d out=%0b expected state=1 out=0", i, state, out);
            end
        end
        cycle(1'b0, 1'b0);
        n_checks++;
        if (state !== 3'd1) begin
            n_errors++;
            $display("FAIL long_pulse_idle: state=%0d expected 1", state);
        end
    endtask

    task automatic test_main_sequence();
        int seq [17] = '{1,2,1,1,2,1,1,1,2,1,1,2,2,1,2,1,1};
`ifdef APPLICATION_OVERLAP_EN
        int exp [17] = '{1,2,3,4,5,3,4,1,2,3,4,5,0,1,2,3,4};
`else
        int exp [17] = '{1,2,3,4,5,1,1,1,2,3,4,5,0,1,2,3,4};
`endif
        do_reset();
        for (int i = 0; i < 17; i++) begin
            cycle(seq[i] == 1, seq[i] == 2);
            n_checks++;
            if (state !== 3'(exp[i]) || exp[i] != m_state || out !== (exp[i] == 5)) begin
                n_errors++;
                $display("FAIL main_seq[%0d]: state=%0d out=%0b expected state=%0d out=%0b model=%0d",
                         i, state, out, exp[i], exp[i] == 5, m_state);
            end
            cycle(1'b0, 1'b0);
            n_checks++;
            if (state !== 3'(exp[i]) || out !== (exp[i] == 5)) begin
                n_errors++;
                $display("FAIL main_seq_idle[%0d]: state=%0d out=%0b expected state=%0d", i, state, out, exp[i]);
            end
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        cycle(1'b1, 1'b0); cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b1); cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b0); cycle(1'b0, 1'b0);
        n_checks++;
        if (state !== 3'd3) begin
            n_errors++;
            $display("FAIL simul_setup: state=%0d expected 3", state);
        end
        cycle(1'b1, 1'b1);
        n_checks++;
        if (state !== 3'd0 || out !== 1'b0 || m_state != 0) begin
            n_errors++;
            $display("FAIL simultaneous: state=%0d out=%0b expected state=0 out=0", state, out);
        end
        cycle(1'b0, 1'b0);
    endtask

    task automatic test_mid_reset();
        do_reset();
        cycle(1'b1, 1'b0); cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b1); cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b0); cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b0); cycle(1'b0, 1'b0);
        n_checks++;
        if (state !== 3'd4) begin
            n_errors++;
            $display("FAIL mid_reset_setup: state=%0d expected 4", state);
        end
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        n_checks++;
        if (state !== 3'd0 || out !== 1'b0) begin
            n_errors++;
            $display("FAIL mid_reset_async: state=%0d out=%0b expected state=0 out=0", state, out);
        end
        #1 reset = 1'b0;
        model_clear();
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
        n_checks++;
        if (state !== 3'd0 || m_state != 0) begin
            n_errors++;
            $display("FAIL mid_reset_b: state=%0d expected 0", state);
        end
    endtask

    task automatic test_illegal_code();
        logic [2:0] bad [2] = '{3'b110, 3'b111};
        for (int i = 0; i < 2; i++) begin
            do_reset();
            cycle(1'b1, 1'b0); cycle(1'b0, 1'b0);
            cycle(1'b0, 1'b1); cycle(1'b0, 1'b0);
            @(negedge clk);
            force dut.r_state = bad[i];
            #1;
            n_checks++;
            if (state !== bad[i] || out !== 1'b0) begin
                n_errors++;
                $display("FAIL illegal_forced[%0d]: state=%0d out=%0b expected state=%0d out=0", i, state, out, bad[i]);
            end
            release dut.r_state;
            @(posedge clk);
            #1;
            n_checks++;
            if (state !== 3'd0 || out !== 1'b0) begin
                n_errors++;
                $display("FAIL illegal_recover[%0d]: state=%0d out=%0b expected state=0 out=0", i, state, out);
            end
        end
    endtask

    task automatic test_random();
        logic na;
        logic nb;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            na = ($urandom_range(0, 2) == 0);
            nb = ($urandom_range(0, 2) == 0);
            cycle(na, nb);
            n_checks++;
            if (state !== 3'(m_state) || out !== (m_state == 5)) begin
                n_errors++;
                $display("FAIL random[%0d]: state=%0d out=%0b expected state=%0d out=%0b",
                         i, state, out, m_state, m_state == 5);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        a = 1'b0;
        b = 1'b0;
        model_clear();
        test_reset();
        test_long_pulse();
        test_main_sequence();
        test_simultaneous();
        test_mid_reset();
        test_illegal_code();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
